// File: rtl/cp0_reg.sv
// CP0 register file: Status, Cause, EPC, Count, Compare and BadVAddr, with
// timer interrupt generation, exception/ERET bookkeeping and an MFC0 read
// path that bypasses a same-cycle MTC0 from write-back.
module cp0_reg (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  int_i,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o,
  output logic        int_req_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Architectural state (only the implemented bit fields are stored)
  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic [5:0]  cause_hw_r;
  logic [1:0]  cause_sw_r;
  logic [4:0]  cause_exc_r;
  logic [31:0] epc_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] badvaddr_r;
  logic        tick_r;
  logic        timer_int_r;

  // Next-state values
  logic [7:0]  im_s;
  logic        exl_s;
  logic        ie_s;
  logic [5:0]  cause_hw_s;
  logic [1:0]  cause_sw_s;
  logic [4:0]  cause_exc_s;
  logic [31:0] epc_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic [31:0] badvaddr_s;
  logic        tick_s;
  logic        timer_int_s;

  logic        wr_badvaddr_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic [5:0]  cause_hw_live_s;
  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic [31:0] cause_live_s;

  // Decode the MTC0 target and assemble the architectural register views
  always_comb begin
    wr_badvaddr_s   = we && (waddr == REG_BADVADDR);
    wr_count_s      = we && (waddr == REG_COUNT);
    wr_compare_s    = we && (waddr == REG_COMPARE);
    wr_status_s     = we && (waddr == REG_STATUS);
    wr_cause_s      = we && (waddr == REG_CAUSE);
    wr_epc_s        = we && (waddr == REG_EPC);
    cause_hw_live_s = {int_i[5] | timer_int_r, int_i[4:0]};
    status_s        = {9'd0, 1'b1, 6'd0, im_r, 6'd0, exl_r, ie_r};
    cause_s         = {16'd0, cause_hw_r, cause_sw_r, 1'b0, cause_exc_r, 2'b00};
    cause_live_s    = {16'd0, cause_hw_live_s, cause_sw_r, 1'b0, cause_exc_r, 2'b00};
  end

  // Next-state logic: exception beats ERET beats MTC0 for Status/Cause/EPC
  always_comb begin
    im_s        = im_r;
    exl_s       = exl_r;
    ie_s        = ie_r;
    cause_sw_s  = cause_sw_r;
    cause_exc_s = cause_exc_r;
    epc_s       = epc_r;
    cause_hw_s  = cause_hw_live_s;

    if (exc_valid) begin
      exl_s       = 1'b1;
      cause_exc_s = exc_code;
      if (!exl_r) begin
        epc_s = exc_pc;
      end else begin
        epc_s = epc_r;
      end
    end else if (eret) begin
      exl_s = 1'b0;
    end else begin
      if (wr_status_s) begin
        im_s  = wdata[15:8];
        exl_s = wdata[1];
        ie_s  = wdata[0];
      end else begin
        im_s  = im_r;
      end
      if (wr_cause_s) begin
        cause_sw_s = wdata[9:8];
      end else begin
        cause_sw_s = cause_sw_r;
      end
      if (wr_epc_s) begin
        epc_s = wdata;
      end else begin
        epc_s = epc_r;
      end
    end

    if (exc_valid && ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES))) begin
      badvaddr_s = exc_badvaddr;
    end else if (wr_badvaddr_s) begin
      badvaddr_s = wdata;
    end else begin
      badvaddr_s = badvaddr_r;
    end

    // Count advances on every other clock; a write reloads it and re-phases the tick
    if (wr_count_s) begin
      count_s = wdata;
      tick_s  = 1'b0;
    end else if (tick_r) begin
      count_s = count_r + 32'd1;
      tick_s  = 1'b0;
    end else begin
      count_s = count_r;
      tick_s  = 1'b1;
    end

    if (wr_compare_s) begin
      compare_s = wdata;
    end else begin
      compare_s = compare_r;
    end

    // A Compare write acknowledges the timer even if a match happens in the same cycle
    if (wr_compare_s) begin
      timer_int_s = 1'b0;
    end else if ((compare_r != 32'd0) && (count_r == compare_r)) begin
      timer_int_s = 1'b1;
    end else begin
      timer_int_s = timer_int_r;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      im_r        <= 8'd0;
      exl_r       <= 1'b0;
      ie_r        <= 1'b0;
      cause_hw_r  <= 6'd0;
      cause_sw_r  <= 2'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= 32'd0;
      count_r     <= 32'd0;
      compare_r   <= 32'd0;
      badvaddr_r  <= 32'd0;
      tick_r      <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      im_r        <= im_s;
      exl_r       <= exl_s;
      ie_r        <= ie_s;
      cause_hw_r  <= cause_hw_s;
      cause_sw_r  <= cause_sw_s;
      cause_exc_r <= cause_exc_s;
      epc_r       <= epc_s;
      count_r     <= count_s;
      compare_r   <= compare_s;
      badvaddr_r  <= badvaddr_s;
      tick_r      <= tick_s;
      timer_int_r <= timer_int_s;
    end
  end

  // MFC0 read mux with write-back bypass; Cause shows live interrupt lines
  always_comb begin
    if (we && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      case (raddr)
        REG_BADVADDR: rdata = badvaddr_r;
        REG_COUNT:    rdata = count_r;
        REG_COMPARE:  rdata = compare_r;
        REG_STATUS:   rdata = status_s;
        REG_CAUSE:    rdata = cause_live_s;
        REG_EPC:      rdata = epc_r;
        default:      rdata = 32'd0;
      endcase
    end
  end

  // Register contents and interrupt request towards the exception unit
  always_comb begin
    status_o    = status_s;
    cause_o     = cause_s;
    epc_o       = epc_r;
    count_o     = count_r;
    compare_o   = compare_r;
    badvaddr_o  = badvaddr_r;
    timer_int_o = timer_int_r;
    int_req_o   = ie_r & ~exl_r & (|(cause_hw_r & im_r[7:2]) | |(cause_sw_r & im_r[1:0]));
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed testbench for cp0_reg with hand-computed expected values.
module tb_cp0_reg;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  int_i;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;
  logic        int_req_o;

  int tests_run;
  int tests_failed;

  cp0_reg dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .int_i        (int_i),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .status_o     (status_o),
    .cause_o      (cause_o),
    .epc_o        (epc_o),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .badvaddr_o   (badvaddr_o),
    .timer_int_o  (timer_int_o),
    .int_req_o    (int_req_o)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cpu_rst_n    = 1'b0;
    we           = 1'b0;
    waddr        = 5'd0;
    wdata        = 32'd0;
    raddr        = 5'd0;
    int_i        = 6'd0;
    exc_valid    = 1'b0;
    exc_code     = 5'd0;
    exc_pc       = 32'd0;
    exc_badvaddr = 32'd0;
    eret         = 1'b0;

    // Reset values
    #2;
    check_eq("rst_status", status_o, 32'h0040_0000);
    check_eq("rst_count", count_o, 32'd0);
    check_eq("rst_cause", cause_o, 32'd0);
    check_eq("rst_timer", {31'd0, timer_int_o}, 32'd0);
    step();
    cpu_rst_n = 1'b1;

    // Ten cycles after reset: Count has advanced five times
    for (int i = 0; i < 10; i++) step();
    check_eq("cnt10_status", status_o, 32'h0040_0000);
    check_eq("cnt10_count", count_o, 32'd5);

    // Timer: Compare=0x10, Count=0x0E
    mtc0(5'd11, 32'h0000_0010);
    check_eq("cmp_write", compare_o, 32'h0000_0010);
    mtc0(5'd9, 32'h0000_000E);
    check_eq("cnt_write", count_o, 32'h0000_000E);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("timer_early", {31'd0, timer_int_o}, 32'd0);
    end
    check_eq("cnt_at_match", count_o, 32'h0000_0010);
    step();
    check_eq("timer_set", {31'd0, timer_int_o}, 32'd1);
    step();
    check_eq("timer_hold", {31'd0, timer_int_o}, 32'd1);
    check_eq("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'h0000_0040);
    check_eq("timer_clr", {31'd0, timer_int_o}, 32'd0);

    // Address-error exception
    exc_valid    = 1'b1;
    exc_code     = 5'd4;
    exc_pc       = 32'hBFC0_0100;
    exc_badvaddr = 32'h1234_5671;
    step();
    exc_valid    = 1'b0;
    check_eq("exc_epc", epc_o, 32'hBFC0_0100);
    check_eq("exc_badvaddr", badvaddr_o, 32'h1234_5671);
    check_eq("exc_code", {27'd0, cause_o[6:2]}, 32'd4);
    check_eq("exc_exl", {31'd0, status_o[1]}, 32'd1);
    // Nested exception while EXL=1 keeps EPC; non-address code keeps BadVAddr
    exc_valid    = 1'b1;
    exc_code     = 5'd0;
    exc_pc       = 32'h0000_0200;
    exc_badvaddr = 32'hAAAA_0000;
    step();
    exc_valid    = 1'b0;
    check_eq("exc2_epc", epc_o, 32'hBFC0_0100);
    check_eq("exc2_badvaddr", badvaddr_o, 32'h1234_5671);

    // ERET clears EXL
    eret = 1'b1;
    step();
    eret = 1'b0;
    check_eq("eret1_status", status_o, 32'h0040_0000);

    // Exception and MTC0 Status in the same cycle: MTC0 dropped
    exc_valid = 1'b1;
    exc_code  = 5'd8;
    exc_pc    = 32'h0000_0300;
    mtc0(5'd12, 32'h0000_FF01);
    exc_valid = 1'b0;
    check_eq("exc_mtc0_status", status_o, 32'h0040_0002);
    check_eq("exc_mtc0_epc", epc_o, 32'h0000_0300);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check_eq("eret2_status", status_o, 32'h0040_0000);

    // Hardware interrupt request
    mtc0(5'd12, 32'h0000_0401);
    check_eq("status_wr", status_o, 32'h0040_0401);
    int_i = 6'b000001;
    step();
    check_eq("cause_ip2", {31'd0, cause_o[10]}, 32'd1);
    check_eq("int_req_on", {31'd0, int_req_o}, 32'd1);
    mtc0(5'd12, 32'h0000_0403);
    check_eq("int_req_exl", {31'd0, int_req_o}, 32'd0);
    int_i = 6'd0;
    mtc0(5'd13, 32'hFFFF_FFFF);
    check_eq("cause_sw", {30'd0, cause_o[9:8]}, 32'd3);
    check_eq("cause_code_kept", {27'd0, cause_o[6:2]}, 32'd8);

    // Bypass and read mux
    we    = 1'b1;
    waddr = 5'd14;
    wdata = 32'hDEAD_BEEF;
    raddr = 5'd14;
    #1;
    check_eq("bypass", rdata, 32'hDEAD_BEEF);
    step();
    we = 1'b0;
    #1;
    check_eq("epc_read", rdata, 32'hDEAD_BEEF);
    raddr = 5'd12;
    #1;
    check_eq("status_read", rdata, 32'h0040_0403);
    mtc0(5'd5, 32'h1111_1111);
    raddr = 5'd5;
    #1;
    check_eq("unimpl_read", rdata, 32'd0);

    // Count wraps to zero
    mtc0(5'd9, 32'hFFFF_FFFF);
    step();
    check_eq("wrap_hold", count_o, 32'hFFFF_FFFF);
    step();
    check_eq("wrap_zero", count_o, 32'd0);

    // Reset mid-count takes effect without a clock edge
    for (int i = 0; i < 6; i++) step();
    check_eq("pre_rst_count", count_o, 32'd3);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    check_eq("async_rst_count", count_o, 32'd0);
    check_eq("async_rst_status", status_o, 32'h0040_0000);
    check_eq("async_rst_epc", epc_o, 32'd0);
    #1;
    cpu_rst_n = 1'b1;
    step();
    step();
    check_eq("post_rst_count", count_o, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
